// File: rtl/dp_ram_pkg.sv
// Shared types, read-during-write mode constants and the byte-merge helper
// used by the dual-port RAM bank.
package dp_ram_pkg;

  typedef enum logic [0:0] {
    SEQ_CLEAR = 1'b0,
    SEQ_IDLE  = 1'b1
  } seq_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // The merge works on the widest supported word; callers cast to their width.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_w,
    input logic [MERGE_W-1:0]    new_w,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read return path for one RAM port: a mandatory capture stage plus an
// optional output register stage. rdata holds its value between reads.
module dp_ram_rd_pipe #(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  logic              v1_q;
  logic [DATA_W-1:0] d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_en_i;
      if (rd_en_i) begin
        d1_q <= rd_data_i;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;

      // Reset clears both stages, so a read caught in flight never returns.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            d2_q <= d1_q;
          end
        end
      end

      assign rdata_o  = d2_q;
      assign rvalid_o = v2_q;
    end else begin : g_no_out_reg
      assign rdata_o  = d1_q;
      assign rvalid_o = v1_q;
    end
  endgenerate

endmodule

// File: rtl/dp_ram_bank.sv
// True dual-port RAM bank: byte-enabled writes, same-address write merging
// with collision flag, selectable cross-port read-during-write, power-on clear.
module dp_ram_bank #(
  parameter int  DATA_W         = 8,
  parameter int  DEPTH          = 64,
  parameter int  OUT_REG        = 0,
  parameter int  RDW_NEW        = 0,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int ADDR_W         = $clog2(DEPTH),
  localparam int BE_W           = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [BE_W-1:0]   be_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [BE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              collision,
  output logic              init_busy
);

  import dp_ram_pkg::*;

  localparam bit RDW_IS_NEW = (RDW_NEW == dp_ram_pkg::RDW_NEW);

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [MERGE_W-1:0] m;
    m = byte_merge(MERGE_W'(old_w), MERGE_W'(new_w), MERGE_BE_W'(be));
    return m[DATA_W-1:0];
  endfunction

  // Handshake: en_x is a single-cycle request with no back-pressure; it is
  // accepted on any clock edge where init_busy is 0 and dropped otherwise.
  // rvalid_x is a one-cycle pulse per accepted read, with no ready input.

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              collision_q, collision_d;
  logic              busy;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DATA_W-1:0] word_a_wr, word_b_wr, word_a_base;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  assign busy      = (state_q == SEQ_CLEAR);
  assign init_busy = busy;
  assign collision = collision_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == SEQ_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = SEQ_IDLE;
      end
    end
  end

  always_comb begin
    wr_a      = en_a & we_a & ~busy;
    wr_b      = en_b & we_b & ~busy;
    rd_a      = en_a & ~we_a & ~busy;
    rd_b      = en_b & ~we_b & ~busy;
    same_addr = (addr_a == addr_b);

    // Port B is merged first so that port A overrides it on shared lanes.
    word_b_wr   = merge_word(mem_q[addr_b], wdata_b, be_b);
    word_a_base = (wr_b && same_addr) ? word_b_wr : mem_q[addr_a];
    word_a_wr   = merge_word(word_a_base, wdata_a, be_a);

    rd_word_a = mem_q[addr_a];
    if (RDW_IS_NEW && wr_b && same_addr) begin
      rd_word_a = word_b_wr;
    end
    rd_word_b = mem_q[addr_b];
    if (RDW_IS_NEW && wr_a && same_addr) begin
      rd_word_b = word_a_wr;
    end

    collision_d = wr_a & wr_b & same_addr & (|(be_a & be_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? SEQ_CLEAR : SEQ_IDLE;
      clr_cnt_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      collision_q <= collision_d;
    end
  end

  // Storage is never reset; the clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (wr_b) begin
        mem_q[addr_b] <= word_b_wr;
      end
      if (wr_a) begin
        mem_q[addr_a] <= word_a_wr;
      end
    end
  end

  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd_a),
    .rd_data_i (rd_word_a),
    .rdata_o   (rdata_a),
    .rvalid_o  (rvalid_a)
  );

  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_rd_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd_b),
    .rd_data_i (rd_word_b),
    .rdata_o   (rdata_b),
    .rvalid_o  (rvalid_b)
  );

endmodule

// File: tb/tb_dp_ram_bank.sv
// Bench for dp_ram_bank: two 32-bit instances share stimulus (u0: latency 1,
// old-data RDW; u1: latency 2, new-data RDW) and are checked against a model.
module tb_dp_ram_bank;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 64;
  localparam int LAT2_DUT   = 1;
  localparam int RDWNEW_DUT = 1;

  logic        clk;
  logic        rst_n;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;

  logic [1:0][31:0] rdata_a_w, rdata_b_w;
  logic [1:0]       rvalid_a_w, rvalid_b_w, collision_w, init_busy_w;

  int n_pass  = 0;
  int n_total = 0;

  dp_ram_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(0), .RDW_NEW(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a_w[0]), .rvalid_a(rvalid_a_w[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b_w[0]), .rvalid_b(rvalid_b_w[0]),
    .collision(collision_w[0]), .init_busy(init_busy_w[0])
  );

  dp_ram_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(1), .RDW_NEW(1), .CLEAR_ON_RESET(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a_w[1]), .rvalid_a(rvalid_a_w[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b_w[1]), .rvalid_b(rvalid_b_w[1]),
    .collision(collision_w[1]), .init_busy(init_busy_w[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut%0d: got %h required %h at %0t", nm, d, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] exp_rd_a [2], exp_rd_b [2], s1_d_a [2], s1_d_b [2];
  logic        exp_rv_a [2], exp_rv_b [2], s1_v_a [2], s1_v_b [2];
  logic        exp_coll, exp_busy;
  int          clr_left;

  function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m = m | (32'hFF << (8 * i));
    end
    return (o & ~m) | (n & m);
  endfunction

  task automatic model_reset();
    clr_left = DEPTH;
    exp_coll = 1'b0;
    exp_busy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_rd_a[d] = '0; exp_rd_b[d] = '0; exp_rv_a[d] = 1'b0; exp_rv_b[d] = 1'b0;
      s1_v_a[d] = 1'b0; s1_v_b[d] = 1'b0; s1_d_a[d] = '0; s1_d_b[d] = '0;
    end
  endtask

  task automatic model_step();
    logic        wa, wb, ra, rb;
    logic [31:0] pre_a, pre_b, va, vb;
    if (clr_left > 0) begin
      for (int d = 0; d < 2; d++) mem_m[d][DEPTH - clr_left] = '0;
      clr_left--;
      wa = 1'b0; wb = 1'b0; ra = 1'b0; rb = 1'b0;
    end else begin
      wa = en_a && we_a;  ra = en_a && !we_a;
      wb = en_b && we_b;  rb = en_b && !we_b;
    end
    exp_coll = wa && wb && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
    for (int d = 0; d < 2; d++) begin
      pre_a = mem_m[d][addr_a];
      pre_b = mem_m[d][addr_b];
      // Sequential writes: A after B means A owns the shared lanes.
      if (wb) mem_m[d][addr_b] = merge_m(mem_m[d][addr_b], wdata_b, be_b);
      if (wa) mem_m[d][addr_a] = merge_m(mem_m[d][addr_a], wdata_a, be_a);
      va = (d == RDWNEW_DUT) ? mem_m[d][addr_a] : pre_a;
      vb = (d == RDWNEW_DUT) ? mem_m[d][addr_b] : pre_b;
      if (d == LAT2_DUT) begin
        exp_rv_a[d] = s1_v_a[d];
        if (s1_v_a[d]) exp_rd_a[d] = s1_d_a[d];
        exp_rv_b[d] = s1_v_b[d];
        if (s1_v_b[d]) exp_rd_b[d] = s1_d_b[d];
        s1_v_a[d] = ra;
        if (ra) s1_d_a[d] = va;
        s1_v_b[d] = rb;
        if (rb) s1_d_b[d] = vb;
      end else begin
        exp_rv_a[d] = ra;
        if (ra) exp_rd_a[d] = va;
        exp_rv_b[d] = rb;
        if (rb) exp_rd_b[d] = vb;
      end
    end
    exp_busy = (clr_left > 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rvalid_a",  d, rvalid_a_w[d],  exp_rv_a[d]);
        chk("rvalid_b",  d, rvalid_b_w[d],  exp_rv_b[d]);
        chk("rdata_a",   d, rdata_a_w[d],   exp_rd_a[d]);
        chk("rdata_b",   d, rdata_b_w[d],   exp_rd_b[d]);
        chk("collision", d, collision_w[d], exp_coll);
        chk("init_busy", d, init_busy_w[d], exp_busy);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = '0; wdata_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic op(input logic ea, input logic wa, input logic [3:0] ba, input logic [5:0] aa,
                    input logic [31:0] da, input logic eb, input logic wb, input logic [3:0] bb,
                    input logic [5:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; wdata_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; wdata_b = db;
    @(negedge clk);
    idle();
  endtask

  // Called at the negedge right after the accepting edge of a single read.
  task automatic expect_read(input bit on_b, input logic [31:0] e0, input logic [31:0] e1);
    chk(on_b ? "lit_rvalid_b" : "lit_rvalid_a", 0, on_b ? rvalid_b_w[0] : rvalid_a_w[0], 32'd1);
    chk(on_b ? "lit_rdata_b"  : "lit_rdata_a",  0, on_b ? rdata_b_w[0]  : rdata_a_w[0],  e0);
    @(negedge clk);
    chk(on_b ? "lit_rvalid_b" : "lit_rvalid_a", 1, on_b ? rvalid_b_w[1] : rvalid_a_w[1], 32'd1);
    chk(on_b ? "lit_rdata_b"  : "lit_rdata_a",  1, on_b ? rdata_b_w[1]  : rdata_a_w[1],  e1);
  endtask

  // Counts edges after reset release until init_busy is seen low.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!init_busy_w[0]) break;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int busy_len;
    logic [5:0] ra;
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // A read held during the clear must produce no rvalid.
    en_b = 1'b1; we_b = 1'b0; addr_b = 6'd3;
    count_busy(busy_len);
    chk("lit_busy_len", 0, busy_len, 32'd64);
    idle();
    @(negedge clk);

    op(1'b1, 1'b0, 4'h0, 6'h3F, 32'h0, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    expect_read(1'b0, 32'h0, 32'h0);

    op(1'b1, 1'b1, 4'hF, 6'd5, 32'h0000_00A5, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    expect_read(1'b1, 32'h0000_00A5, 32'h0000_00A5);

    op(1'b1, 1'b1, 4'b0011, 6'd9, 32'h1122_3344, 1'b1, 1'b1, 4'b1110, 6'd9, 32'hAABB_CCDD);
    chk("lit_collision", 0, collision_w[0], 32'd1);
    chk("lit_collision", 1, collision_w[1], 32'd1);
    op(1'b1, 1'b0, 4'h0, 6'd9, 32'h0, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    expect_read(1'b0, 32'hAABB_3344, 32'hAABB_3344);

    // Same address, disjoint lanes: merge without a collision pulse.
    op(1'b1, 1'b1, 4'b0001, 6'd12, 32'h0000_0011, 1'b1, 1'b1, 4'b1000, 6'd12, 32'h2200_0000);
    chk("lit_no_collision", 0, collision_w[0], 32'd0);
    op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 1'b0, 4'h0, 6'd12, 32'h0);
    expect_read(1'b1, 32'h2200_0011, 32'h2200_0011);

    op(1'b1, 1'b1, 4'hF, 6'd2, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    op(1'b1, 1'b1, 4'hF, 6'd2, 32'h0000_0020, 1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    expect_read(1'b1, 32'h0000_0010, 32'h0000_0020);
    op(1'b1, 1'b1, 4'h0, 6'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    expect_read(1'b1, 32'h0000_0020, 32'h0000_0020);

    // Reset lands while u1 still holds a read in its output pipeline.
    op(1'b1, 1'b1, 4'hF, 6'd40, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    op(1'b1, 1'b0, 4'h0, 6'd40, 32'h0, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(busy_len);
    chk("lit_busy_len_restart", 0, busy_len, 32'd64);
    @(negedge clk);
    op(1'b1, 1'b0, 4'h0, 6'd40, 32'h0, 1'b1, 1'b0, 4'h0, 6'd0, 32'h0);
    expect_read(1'b0, 32'h0, 32'h0);

    // Random fill, then mixed traffic on a narrow address window.
    for (int i = 0; i < 64; i++) begin
      ra = 6'($urandom_range(0, 63));
      en_a = 1'b1; we_a = 1'b1; be_a = 4'($urandom_range(0, 15)); addr_a = ra; wdata_a = $urandom;
      en_b = 1'b1; we_b = 1'b1; be_b = 4'($urandom_range(0, 15));
      addr_b = ($urandom_range(0, 3) == 0) ? ra : 6'($urandom_range(0, 63));
      wdata_b = $urandom;
      @(negedge clk);
    end
    for (int i = 0; i < 60; i++) begin
      en_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
      be_a = 4'($urandom_range(0, 15)); addr_a = 6'($urandom_range(0, 7)); wdata_a = $urandom;
      en_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      be_b = 4'($urandom_range(0, 15)); addr_b = 6'($urandom_range(0, 7)); wdata_b = $urandom;
      @(negedge clk);
    end
    for (int i = 0; i < 100; i++) begin
      ra = 6'($urandom_range(0, 63));
      en_a = 1'b1; we_a = 1'b0; addr_a = ra;
      en_b = 1'b1; we_b = 1'b0; addr_b = ra ^ 6'($urandom_range(1, 63));
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
